adc_dual_channel_reader: RTL and testbench

SPI master that continuously samples two channels of the external 12-bit ADC over ADC_SCLK/ADC_CS_N/ADC_DIN/ADC_DOUT. It presents the latest conversions as registered 12-bit words CH0 and CH1 with per-channel update strobes. It sits directly upstream of the setpoint subtractors in the cascaded PI loop: CH0 is the outer-loop feedback and CH1 is the inner-loop feedback.

---
 rtl/adc_dual_channel_reader.sv | 178 +++++++++++++++++
 tb/tb_adc_dual_channel_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dual_channel_reader.sv
// SPI reader for a 12-bit ADC that alternates between two mux addresses and
// presents CH0/CH1 with update strobes. Define ADC_AVG_EN for 2-sample averaging.
module adc_dual_channel_reader #(
  parameter int         CLK_DIV  = 2,
  parameter int         CS_GAP   = 4,
  parameter logic [2:0] CH0_ADDR = 3'd0,
  parameter logic [2:0] CH1_ADDR = 3'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ADC_DOUT,
  output logic        ADC_SCLK,
  output logic        ADC_CS_N,
  output logic        ADC_DIN,
  output logic [11:0] CH0,
  output logic [11:0] CH1,
  output logic        ch0_valid,
  output logic        ch1_valid,
  output logic        busy
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_reg;
  logic [15:0]      shift_reg;
  logic             frame_odd_reg;
  logic             discard_reg;

  logic [15:0] addr_word;
  logic [3:0]  bit_next;
  logic [11:0] raw;
  logic        frame_end;
  logic [1:0]  deliver;
  logic [11:0] ch_new [2];

  // Even frames request CH0_ADDR; the ADC answers one frame later.
  assign addr_word = {2'b00, (frame_odd_reg ? CH1_ADDR : CH0_ADDR), 11'b0};
  assign bit_next  = bit_reg + 4'd1;
  assign raw       = shift_reg[11:0];
  assign frame_end = (state_reg == SHIFT_HI) && (cnt_reg == DIV_LAST) && (bit_reg == 4'd15);
  assign deliver[0] = frame_end && !discard_reg && frame_odd_reg;
  assign deliver[1] = frame_end && !discard_reg && !frame_odd_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
`ifdef ADC_AVG_EN
      logic [11:0] prev_reg;
      logic        have_reg;
      logic [12:0] sum;

      assign sum        = {1'b0, raw} + {1'b0, prev_reg};
      assign ch_new[gi] = have_reg ? sum[12:1] : raw;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prev_reg <= 12'd0;
          have_reg <= 1'b0;
        end else if (deliver[gi]) begin
          prev_reg <= raw;
          have_reg <= 1'b1;
        end
      end
`else
      assign ch_new[gi] = raw;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= 4'd0;
      shift_reg     <= 16'd0;
      frame_odd_reg <= 1'b0;
      discard_reg   <= 1'b1;
      ADC_SCLK      <= 1'b1;
      ADC_CS_N      <= 1'b1;
      ADC_DIN       <= 1'b0;
      CH0           <= 12'd0;
      CH1           <= 12'd0;
      ch0_valid     <= 1'b0;
      ch1_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ch0_valid <= 1'b0;
      ch1_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          ADC_CS_N <= 1'b1;
          ADC_SCLK <= 1'b1;
          if (en) begin
            state_reg <= SETUP;
            cnt_reg   <= '0;
            ADC_CS_N  <= 1'b0;
            ADC_DIN   <= addr_word[15];
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            bit_reg   <= 4'd0;
            state_reg <= SHIFT_LO;
            ADC_SCLK  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        SHIFT_LO: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            state_reg <= SHIFT_HI;
            ADC_SCLK  <= 1'b1;
            shift_reg <= {shift_reg[14:0], ADC_DOUT};
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= '0;
            if (bit_reg == 4'd15) begin
              state_reg     <= GAP;
              ADC_CS_N      <= 1'b1;
              ADC_DIN       <= 1'b0;
              frame_odd_reg <= ~frame_odd_reg;
              discard_reg   <= 1'b0;
            end else begin
              bit_reg   <= bit_next;
              state_reg <= SHIFT_LO;
              ADC_SCLK  <= 1'b0;
              ADC_DIN   <= addr_word[4'd15 - bit_next];
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg <= '0;
            if (en) begin
              state_reg <= SETUP;
              ADC_CS_N  <= 1'b0;
              ADC_DIN   <= addr_word[15];
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Results land in the same cycle CS_N rises.
      if (deliver[0]) begin
        CH0       <= ch_new[0];
        ch0_valid <= 1'b1;
      end
      if (deliver[1]) begin
        CH1       <= ch_new[1];
        ch1_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_dual_channel_reader.sv
// Randomized bench for adc_dual_channel_reader with a pipelined ADC model and
// a frame-level scoreboard; honours ADC_AVG_EN in the expected values.
module tb_adc_dual_channel_reader;

  localparam int         CLK_DIV = 2;
  localparam int         CS_GAP  = 4;
  localparam logic [2:0] CH0_A   = 3'd0;
  localparam logic [2:0] CH1_A   = 3'd5;
  localparam int         TCLK    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        ADC_DOUT = 1'b0;
  logic        ADC_SCLK, ADC_CS_N, ADC_DIN;
  logic [11:0] CH0, CH1;
  logic        ch0_valid, ch1_valid, busy;

  adc_dual_channel_reader #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP),
    .CH0_ADDR(CH0_A),
    .CH1_ADDR(CH1_A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ADC_DOUT (ADC_DOUT),
    .ADC_SCLK (ADC_SCLK),
    .ADC_CS_N (ADC_CS_N),
    .ADC_DIN  (ADC_DIN),
    .CH0      (CH0),
    .CH1      (CH1),
    .ch0_valid(ch0_valid),
    .ch1_valid(ch1_valid),
    .busy     (busy)
  );

  always #(TCLK/2) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ADC model: samples DIN on SCLK rise, drives DOUT after SCLK fall,
  // returns the conversion for the address received in the previous frame.
  logic [11:0] conv [8];
  logic [2:0]  last_addr = 3'd0;
  logic [15:0] tx = 16'd0, rx = 16'd0;
  logic [11:0] sent_val = 12'd0;
  int          bitcnt = 0;
  bit          rand_mode = 1'b0;
  bit          gap_chk = 1'b0;
  bit          have_rise = 1'b0;
  time         fall_t = 0, rise_t = 0;

  // Frame-level reference: frame k answers the address sent in frame k-1.
  int          k = 0;
  int          exp_ch = -1;
  bit          check_due = 1'b0;
  logic [11:0] m_ch   [2];
  logic [11:0] m_prev [2];
  bit          m_have [2];

  always @(negedge ADC_CS_N) begin
    if (gap_chk && have_rise)
      check("cs_gap", 32'($time - rise_t), 32'(CS_GAP * TCLK));
    fall_t   = $time;
    bitcnt   = 0;
    rx       = 16'd0;
    sent_val = rand_mode ? 12'($urandom_range(0, 4095)) : conv[last_addr];
    tx       = {4'($urandom_range(0, 15)), sent_val};
  end

  always @(negedge ADC_SCLK) begin
    if (ADC_CS_N == 1'b0 && bitcnt < 16) ADC_DOUT = tx[15 - bitcnt];
  end

  always @(posedge ADC_SCLK) begin
    if (ADC_CS_N == 1'b0) begin
      rx     = {rx[14:0], ADC_DIN};
      bitcnt = bitcnt + 1;
    end
  end

  always @(posedge ADC_CS_N) begin
    if (bitcnt == 16) begin
      logic [15:0] exp_word;
      logic [12:0] s;
      int          ch;
      check("frame_len", 32'($time - fall_t), 32'(33 * CLK_DIV * TCLK));
      exp_word = {2'b00, ((k % 2 == 0) ? CH0_A : CH1_A), 11'b0};
      check("din_word", rx, exp_word);
      last_addr = rx[13:11];
      if (k >= 1) begin
        ch = (k % 2 == 1) ? 0 : 1;
`ifdef ADC_AVG_EN
        s = {1'b0, sent_val} + {1'b0, m_prev[ch]};
        m_ch[ch] = m_have[ch] ? s[12:1] : sent_val;
`else
        s = 13'd0;
        m_ch[ch] = sent_val;
`endif
        m_prev[ch] = sent_val;
        m_have[ch] = 1'b1;
        exp_ch = ch;
      end else begin
        exp_ch = -1;
      end
      $display("frame %0d: din=%h dout=%h -> ch%0d=%h", k, rx, tx, exp_ch, (exp_ch >= 0) ? m_ch[exp_ch] : 12'h000);
      k         = k + 1;
      rise_t    = $time;
      have_rise = 1'b1;
      check_due = 1'b1;
    end
    bitcnt = 0;
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (check_due) begin
        check("ch0_valid", ch0_valid, exp_ch == 0);
        check("ch1_valid", ch1_valid, exp_ch == 1);
        check("ch0_value", CH0, m_ch[0]);
        check("ch1_value", CH1, m_ch[1]);
        check_due = 1'b0;
      end else begin
        check("no_valid", {ch0_valid, ch1_valid}, 2'b00);
      end
    end
  end

  task automatic model_reset();
    k = 0;
    exp_ch = -1;
    check_due = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ch[i] = 12'd0;
      m_prev[i] = 12'd0;
      m_have[i] = 1'b0;
    end
  endtask

  task automatic wait_valid(input int which, input int budget, input string tag, output int at_cyc);
    logic found;
    found = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ((which == 0 && ch0_valid) || (which == 1 && ch1_valid) ||
          (which == 2 && (ch0_valid || ch1_valid))) begin
        found = 1'b1;
        at_cyc = cyc;
      end
    end
    check(tag, found, 1'b1);
  endtask

  task automatic wait_bit(input int b, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ADC_CS_N == 1'b0 && bitcnt == b) found = 1'b1;
    end
    check(tag, found, 1'b1);
  endtask

  localparam logic [29:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};

  initial begin
    #(TCLK * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1;
    logic [11:0] a_exp [4];
    logic [11:0] a_in  [4];

    for (int i = 0; i < 8; i++) conv[i] = 12'h000;
    model_reset();

    // Reset held, then released with en low.
    repeat (3) @(negedge clk);
    check("rst_hold", {ADC_SCLK, ADC_CS_N, ADC_DIN, busy, ch0_valid, ch1_valid, CH0, CH1}, RST_VEC);
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_en0", {ADC_SCLK, ADC_CS_N, ADC_DIN, busy, ch0_valid, ch1_valid, CH0, CH1}, RST_VEC);
    end

    // Steady state with fixed conversions.
    conv[CH0_A] = 12'hABC;
    conv[CH1_A] = 12'h123;
    gap_chk = 1'b1;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 check("cs_fall_first", {ADC_CS_N, busy}, 2'b01);
    wait_valid(0, 200, "steady_ch0_seen", t0);
    check("steady_ch0", CH0, 12'hABC);
    wait_valid(1, 100, "steady_ch1_seen", t1);
    check("steady_ch1", CH1, 12'h123);
    check("valid_spacing", 32'(t1 - t0), 32'(33 * CLK_DIV + CS_GAP));

    // Drop enable during bit 7 of frame 3.
    wait_bit(7, 100, "drop_bit7");
    check("drop_frame3", 32'(k), 32'd3);
    en = 1'b0;
    gap_chk = 1'b0;
    wait_valid(0, 100, "drop_ch0_seen", t0);
    check("drop_ch0", CH0, 12'hABC);
    repeat (CS_GAP + 1) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("drop_idle", {ADC_CS_N, ADC_SCLK, busy}, 3'b110);
    end
    conv[CH1_A] = 12'h456;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 check("cs_fall_reen", {ADC_CS_N, busy}, 2'b01);
    wait_valid(1, 100, "reen_ch1_seen", t1);
    check("reen_ch1", CH1, 12'h456);

    // Asynchronous reset during bit 9.
    wait_bit(9, 200, "rst_bit9");
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_mid_pins", {ADC_CS_N, ADC_SCLK, busy}, 3'b110);
    check("rst_mid_ch", {ch0_valid, ch1_valid, CH0, CH1}, 26'd0);
    repeat (3) @(negedge clk);
    conv[CH0_A] = 12'h100;
    rst = 1'b1;

    // CH0 sample sequence; first sample after reset loads directly.
    a_in[0] = 12'h100; a_in[1] = 12'h200; a_in[2] = 12'hFFF; a_in[3] = 12'hFFF;
`ifdef ADC_AVG_EN
    a_exp[0] = 12'h100; a_exp[1] = 12'h180; a_exp[2] = 12'h8FF; a_exp[3] = 12'hFFF;
`else
    a_exp[0] = 12'h100; a_exp[1] = 12'h200; a_exp[2] = 12'hFFF; a_exp[3] = 12'hFFF;
`endif
    for (int i = 0; i < 4; i++) begin
      conv[CH0_A] = a_in[i];
      wait_valid(0, 220, "avg_ch0_seen", t0);
      check("avg_ch0", CH0, a_exp[i]);
    end

    // Random data with random enable drops.
    rand_mode = 1'b1;
    for (int it = 0; it < 6; it++) begin
      wait_valid(2, 100, "rnd_first", t0);
      gap_chk = 1'b1;
      repeat ($urandom_range(2, 4)) wait_valid(2, 100, "rnd_valid", t0);
      gap_chk = 1'b0;
      repeat ($urandom_range(0, 60)) @(negedge clk);
      en = 1'b0;
      repeat ($urandom_range(80, 160)) @(negedge clk);
      check("rnd_idle", {ADC_CS_N, busy}, 2'b10);
      en = 1'b1;
    end
    en = 1'b0;
    repeat (100) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
